// File: rtl/adder_32.sv
// 32-bit ripple-carry add/subtract unit with signed-overflow and carry flags; ADDER_32_FLAGS_EN adds zero/negative outputs.
// Latency: 1 cycle, all outputs registered; throughput one operation per cycle.
// Backpressure: none, registers load every cycle and consumers qualify with out_valid.

module adder_32_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (ci & (x ^ y));
endmodule

module adder_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             carry,
  output logic             out_valid
`ifdef ADDER_32_FLAGS_EN
  ,
  output logic             zero,
  output logic             negative
`endif
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  logic             ovf;

  // Subtract is a + ~b + 1: invert b and feed sub in as the carry-in.
  assign bb   = b ^ {WIDTH{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    adder_32_fa u_fa (
      .x   (a[i]),
      .y   (bb[i]),
      .ci  (c[i]),
      .sum (sum[i]),
      .co  (c[i+1])
    );
  end

  assign ovf = c[WIDTH-1] ^ c[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      overflow  <= 1'b0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s         <= sum;
      overflow  <= ovf;
      carry     <= c[WIDTH];
      out_valid <= in_valid;
    end
  end

`ifdef ADDER_32_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      zero     <= (sum == '0);
      negative <= sum[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_adder_32.sv
// Scoreboard bench for adder_32: a driver pushes reference results, a negedge monitor pops and compares.
module tb_adder_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        in_valid;
  logic [31:0] s;
  logic        overflow;
  logic        carry;
  logic        out_valid;
`ifdef ADDER_32_FLAGS_EN
  logic        zero;
  logic        negative;
`endif

  adder_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .in_valid  (in_valid),
    .s         (s),
    .overflow  (overflow),
    .carry     (carry),
    .out_valid (out_valid)
`ifdef ADDER_32_FLAGS_EN
    ,
    .zero      (zero),
    .negative  (negative)
`endif
  );

  typedef struct {
    logic [31:0] s;
    logic        ovf;
    logic        cy;
    logic        z;
    logic        n;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: signed result range decides overflow, unsigned comparison decides carry.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic op_sub);
    exp_t   e;
    longint sx;
    longint sy;
    longint r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = op_sub ? sx - sy : sx + sy;
    e.s   = op_sub ? x - y : x + y;
    e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    if (op_sub) e.cy = (x >= y);
    else        e.cy = ({32'd0, x} + {32'd0, y}) > 64'h0000_0000_FFFF_FFFF;
    e.z = (e.s == 32'd0);
    e.n = e.s[31];
    return e;
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic op_sub, input logic vld);
    @(posedge clk);
    #1;
    a        = x;
    b        = y;
    sub      = op_sub;
    in_valid = vld;
    if (vld) q.push_back(model(x, y, op_sub));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got s=0x%08h with no operation pending", s);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("s", s, e.s);
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check("carry", {31'd0, carry}, {31'd0, e.cy});
`ifdef ADDER_32_FLAGS_EN
        check("zero", {31'd0, zero}, {31'd0, e.z});
        check("negative", {31'd0, negative}, {31'd0, e.n});
`endif
      end
    end
  end

  initial begin
    rst_n    = 1'b1;
    a        = '0;
    b        = '0;
    sub      = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("reset_s", s, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_carry", {31'd0, carry}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    drive(32'd5,          32'd7, 1'b0, 1'b1);
    drive(32'h7FFF_FFFF,  32'd1, 1'b0, 1'b1);
    drive(32'hFFFF_FFFF,  32'd1, 1'b0, 1'b1);
    drive(32'd3,          32'd5, 1'b1, 1'b1);
    drive(32'h8000_0000,  32'd1, 1'b1, 1'b1);
    drive(32'h1234_5678,  32'h1234_5678, 1'b1, 1'b1);
    drive(32'h8000_0000,  32'h8000_0000, 1'b0, 1'b1);
    drive(32'd0,          32'd0, 1'b1, 1'b1);
    drive(32'd0,          32'd0, 1'b0, 1'b0);

    // Reset while a result is in flight: it must be discarded.
    drive(32'd100, 32'd23, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_s", s, 32'd0);
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", {31'd0, out_valid}, 32'd0);

    // Random back-to-back traffic with boundary operands mixed in.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: x = 32'h7FFF_FFFF;
        1: x = 32'h8000_0000;
        2: y = x;
        3: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      drive(x, y, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0));
    end
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1);
  end

endmodule
